// File: rtl/serial_cmp_ctrl_pkg.sv
// Shared definitions for the serial magnitude comparator: status codes and FSM states.
//   CMP_EQ / CMP_AGT / CMP_BGT : (y,z) status encodings (00 is never driven)
//   state_t                    : controller state codes
package serial_cmp_ctrl_pkg;

    typedef logic [1:0] cmp_status_t;

    localparam cmp_status_t CMP_EQ  = 2'b01;
    localparam cmp_status_t CMP_AGT = 2'b10;
    localparam cmp_status_t CMP_BGT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

endpackage : serial_cmp_ctrl_pkg

// File: rtl/serial_cmp_ctrl_if.sv
// Command/result bundle between a requester and serial_cmp_ctrl.
//   start, a, b                    : request and operands (requester -> comparator)
//   busy, done                     : progress and one-cycle verdict pulse
//   y, z                           : status pair, eq/a_gt_b/b_gt_a : held verdict flags
//   bit_idx                        : index of the bit under comparison
interface serial_cmp_ctrl_if #(
    parameter int unsigned WIDTH = 16
);
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             y;
    logic             z;
    logic             eq;
    logic             a_gt_b;
    logic             b_gt_a;
    logic [IDX_W-1:0] bit_idx;

    modport master (
        output start, a, b,
        input  busy, done, y, z, eq, a_gt_b, b_gt_a, bit_idx
    );

    modport slave (
        input  start, a, b,
        output busy, done, y, z, eq, a_gt_b, b_gt_a, bit_idx
    );

endinterface : serial_cmp_ctrl_if

// File: rtl/serial_cmp_ctrl_cmp_bit_cell.sv
// One MSB-first compare step: next (y,z) status from current status and one bit pair.
// Status is sticky once it leaves "equal so far".
//   yz_i  : current status
//   a_bit : bit of operand A, b_bit : bit of operand B
//   yz_o  : next status (combinational)
module cmp_bit_cell
    import serial_cmp_ctrl_pkg::*;
(
    input  cmp_status_t yz_i,
    input  logic        a_bit,
    input  logic        b_bit,
    output cmp_status_t yz_o
);

    always_comb begin
        yz_o = yz_i;
        if (yz_i == CMP_EQ) begin
            if (a_bit && !b_bit) begin
                yz_o = CMP_AGT;
            end else if (!a_bit && b_bit) begin
                yz_o = CMP_BGT;
            end
        end
    end

endmodule : cmp_bit_cell

// File: rtl/serial_cmp_ctrl.sv
// Sequential MSB-first magnitude comparator controller with early termination.
//   clk, rst : clock, synchronous active-high reset
//   bus      : serial_cmp_ctrl_if slave (start/a/b in, busy/done/status/flags/bit_idx out)
module serial_cmp_ctrl
    import serial_cmp_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    serial_cmp_ctrl_if.slave bus
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [IDX_W-1:0] idx_q;
    cmp_status_t      yz_q;
    cmp_status_t      yz_step;
    logic             busy_q;
    logic             done_q;
    logic             eq_q;
    logic             agt_q;
    logic             bgt_q;

    // Compare cell looks at the current MSBs of both shift registers.
    cmp_bit_cell u_cell (
        .yz_i  (yz_q),
        .a_bit (a_sh_q[WIDTH-1]),
        .b_bit (b_sh_q[WIDTH-1]),
        .yz_o  (yz_step)
    );

    // Controller FSM; every output is a register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            idx_q   <= IDX_W'(WIDTH - 1);
            yz_q    <= CMP_EQ;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            eq_q    <= 1'b0;
            agt_q   <= 1'b0;
            bgt_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_COMPARE: begin
                    if (yz_step == CMP_EQ && idx_q != '0) begin
                        a_sh_q <= {a_sh_q[WIDTH-2:0], 1'b0};
                        b_sh_q <= {b_sh_q[WIDTH-2:0], 1'b0};
                        idx_q  <= idx_q - IDX_W'(1);
                    end else begin
                        // Verdict: first difference found, or all bits equal.
                        yz_q    <= yz_step;
                        eq_q    <= (yz_step == CMP_EQ);
                        agt_q   <= (yz_step == CMP_AGT);
                        bgt_q   <= (yz_step == CMP_BGT);
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request.
                    if (bus.start) begin
                        a_sh_q  <= bus.a;
                        b_sh_q  <= bus.b;
                        idx_q   <= IDX_W'(WIDTH - 1);
                        yz_q    <= CMP_EQ;
                        eq_q    <= 1'b0;
                        agt_q   <= 1'b0;
                        bgt_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_COMPARE;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.y       = yz_q[1];
    assign bus.z       = yz_q[0];
    assign bus.eq      = eq_q;
    assign bus.a_gt_b  = agt_q;
    assign bus.b_gt_a  = bgt_q;
    assign bus.bit_idx = idx_q;

endmodule : serial_cmp_ctrl

// File: tb/tb_serial_cmp_ctrl.sv
// Self-checking bench for serial_cmp_ctrl (WIDTH=16): vector table, corner sequences, random runs.
module tb_serial_cmp_ctrl;

    localparam int unsigned W = 16;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  yz;
        logic        eq;
        logic        agt;
        logic        bgt;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    serial_cmp_ctrl_if #(.WIDTH(W)) bus ();

    serial_cmp_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Index of first differing bit, MSB first, turned into cycles to verdict.
    function automatic int model_lat(input logic [15:0] a, input logic [15:0] b);
        for (int i = 15; i >= 0; i--) begin
            if (a[i] != b[i]) return 16 - i;
        end
        return 16;
    endfunction

    // Called #1 after a posedge. Issues start, returns cycles from E0 to done (-1 on timeout).
    task automatic run_cmp(input logic [15:0] a, input logic [15:0] b, output int lat);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = -1;
        for (int k = 1; k <= W + 4; k++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic chk_verdict(input string tag, input logic [1:0] yz, input logic e,
                               input logic ag, input logic bg);
        chk({tag, ".yz"},    {30'd0, bus.y, bus.z}, {30'd0, yz});
        chk({tag, ".flags"}, {29'd0, bus.eq, bus.a_gt_b, bus.b_gt_a}, {29'd0, e, ag, bg});
        chk({tag, ".busy"},  {31'd0, bus.busy}, 32'd0);
    endtask

    vec_t vecs[8];
    int   lat;

    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        vecs[0] = '{16'hDAB5, 16'hDABF, 2'b11, 1'b0, 1'b0, 1'b1, 13};
        vecs[1] = '{16'h8000, 16'h7FFF, 2'b10, 1'b0, 1'b1, 1'b0, 1};
        vecs[2] = '{16'hDAB5, 16'hDAB5, 2'b01, 1'b1, 1'b0, 1'b0, 16};
        vecs[3] = '{16'h0001, 16'h0000, 2'b10, 1'b0, 1'b1, 1'b0, 16};
        vecs[4] = '{16'h0000, 16'h0001, 2'b11, 1'b0, 1'b0, 1'b1, 16};
        vecs[5] = '{16'h1234, 16'h1334, 2'b11, 1'b0, 1'b0, 1'b1, 8};
        vecs[6] = '{16'h4000, 16'h0000, 2'b10, 1'b0, 1'b1, 1'b0, 2};
        vecs[7] = '{16'h0000, 16'h0000, 2'b01, 1'b1, 1'b0, 1'b0, 16};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst.busy", {31'd0, bus.busy}, 32'd0);
        chk("rst.done", {31'd0, bus.done}, 32'd0);
        chk_verdict("rst", 2'b01, 1'b0, 1'b0, 1'b0);
        chk("rst.idx", {28'd0, bus.bit_idx}, 32'd15);

        // Directed table
        foreach (vecs[i]) begin
            run_cmp(vecs[i].a, vecs[i].b, lat);
            chk($sformatf("vec%0d.lat", i), lat, vecs[i].lat);
            chk_verdict($sformatf("vec%0d", i), vecs[i].yz, vecs[i].eq, vecs[i].agt, vecs[i].bgt);
            @(posedge clk); #1;
            chk($sformatf("vec%0d.pulse", i), {31'd0, bus.done}, 32'd0);
            chk_verdict($sformatf("vec%0d.hold", i), vecs[i].yz, vecs[i].eq, vecs[i].agt, vecs[i].bgt);
        end

        // bit_idx walk on equal operands
        bus.start = 1'b1; bus.a = 16'hDAB5; bus.b = 16'hDAB5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("walk%0d.idx", k), {28'd0, bus.bit_idx}, 32'(15 - k));
            chk($sformatf("walk%0d.busy", k), {31'd0, bus.busy}, 32'd1);
            @(posedge clk); #1;
        end
        chk("walk.done", {31'd0, bus.done}, 32'd1);
        chk_verdict("walk", 2'b01, 1'b1, 1'b0, 1'b0);

        // Mid-run start ignored, then start in DONE cycle accepted
        @(posedge clk); #1;
        bus.start = 1'b1; bus.a = 16'hDAB5; bus.b = 16'hDABF;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = -1;
        for (int k = 1; k <= W + 4; k++) begin
            bus.start = (k == 3);
            if (k == 3) begin bus.a = 16'h0000; bus.b = 16'hFFFF; end
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (bus.done) begin lat = k; break; end
        end
        chk("mid.lat", lat, 13);
        chk_verdict("mid", 2'b11, 1'b0, 1'b0, 1'b1);
        bus.start = 1'b1; bus.a = 16'h0000; bus.b = 16'hFFFF;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("b2b.busy", {31'd0, bus.busy}, 32'd1);
        chk("b2b.flagsclr", {29'd0, bus.eq, bus.a_gt_b, bus.b_gt_a}, 32'd0);
        @(posedge clk); #1;
        chk("b2b.done", {31'd0, bus.done}, 32'd1);
        chk_verdict("b2b", 2'b11, 1'b0, 1'b0, 1'b1);

        // Reset mid-run aborts with no done
        @(posedge clk); #1;
        bus.start = 1'b1; bus.a = 16'h5555; bus.b = 16'h5555;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort.busy", {31'd0, bus.busy}, 32'd0);
        chk("abort.done", {31'd0, bus.done}, 32'd0);
        chk_verdict("abort", 2'b01, 1'b0, 1'b0, 1'b0);
        chk("abort.idx", {28'd0, bus.bit_idx}, 32'd15);
        begin
            int seen = 0;
            for (int k = 0; k < 20; k++) begin
                @(posedge clk); #1;
                if (bus.done || bus.busy) seen++;
            end
            chk("abort.quiet", seen, 0);
        end
        run_cmp(16'h00F0, 16'h00E0, lat);
        chk("after.lat", lat, 12);
        chk_verdict("after", 2'b10, 1'b0, 1'b1, 1'b0);

        // Random runs against integer comparison
        for (int r = 0; r < 500; r++) begin
            logic [15:0] ra, rb;
            logic [1:0]  eyz;
            ra = 16'($urandom);
            rb = (r % 5 == 0) ? ra ^ 16'(1 << $urandom_range(0, 15)) : 16'($urandom);
            if (r % 50 == 0) rb = ra;
            eyz = (ra > rb) ? 2'b10 : (ra < rb) ? 2'b11 : 2'b01;
            @(posedge clk); #1;
            run_cmp(ra, rb, lat);
            chk($sformatf("rnd%0d.lat", r), lat, model_lat(ra, rb));
            chk_verdict($sformatf("rnd%0d", r), eyz, ra == rb, ra > rb, ra < rb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_serial_cmp_ctrl
